// File: rtl/axil_csr_responder.sv
// AXI4-Lite slave terminating single-outstanding write/read channels onto a bank
// of 32-bit RW registers plus one read-only status word at the top index.
module axil_csr_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_REGS   = 16
) (
  input  logic                               ACLK,
  input  logic                               ARESET_N,
  input  logic [ADDR_WIDTH-1:0]              AWADDR,
  input  logic                               AWVALID,
  output logic                               AWREADY,
  input  logic [DATA_WIDTH-1:0]              WDATA,
  input  logic [DATA_WIDTH/8-1:0]            WSTRB,
  input  logic                               WVALID,
  output logic                               WREADY,
  output logic [1:0]                         BRESP,
  output logic                               BVALID,
  input  logic                               BREADY,
  input  logic [ADDR_WIDTH-1:0]              ARADDR,
  input  logic                               ARVALID,
  output logic                               ARREADY,
  output logic [DATA_WIDTH-1:0]              RDATA,
  output logic [1:0]                         RRESP,
  output logic                               RVALID,
  input  logic                               RREADY,
  input  logic [DATA_WIDTH-1:0]              status_in,
  output logic [DATA_WIDTH*(NUM_REGS-1)-1:0] reg_q
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // One extra bit so the compare stays correct when NUM_REGS fills the index space.
  localparam logic [IDX_W:0] STATUS_IDX = (IDX_W+1)'(NUM_REGS - 1);

  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB-1:0]         w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];

  logic                  aw_hs, w_hs, ar_hs, commit, wr_is_rw;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [NB-1:0]         wr_strb;
  logic [1:0]            rd_resp;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = !aw_full_q && !bvalid_q;
  assign WREADY  = !w_full_q && !bvalid_q;
  assign ARREADY = !rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A beat arriving this cycle joins with a held partner without a latch round-trip.
  assign wr_idx   = aw_full_q ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data  = w_full_q ? w_data_q : WDATA;
  assign wr_strb  = w_full_q ? w_strb_q : WSTRB;
  assign commit   = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;
  assign wr_is_rw = {1'b0, wr_idx} < STATUS_IDX;
  assign rd_idx   = ARADDR[ADDR_WIDTH-1:2];

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    if ({1'b0, rd_idx} < STATUS_IDX) begin
      rd_resp = RESP_OKAY;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
      end
    end else if ({1'b0, rd_idx} == STATUS_IDX) begin
      rd_resp = RESP_OKAY;
      rd_word = status_in;
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_is_rw ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = WDATA;
        w_strb_d = WSTRB;
      end
    end
    if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_resp;
      rdata_d  = rd_word;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
    end else if (commit && wr_is_rw) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_idx == IDX_W'(i) && wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_flat
    assign reg_q[DATA_WIDTH*g +: DATA_WIDTH] = regs_q[g];
  end

endmodule
